// File: rtl/shift_register_param.sv
// rtl/shift_register_param.sv - parametrised Booth operand shift register with burst shift
// Optional left shift port enabled by defining SHIFT_REGISTER_SHL_EN.
module shift_register_param #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x_in,
  input  logic             ld,
  input  logic             s_in,
  input  logic             shr,
`ifdef SHIFT_REGISTER_SHL_EN
  input  logic             shl,
`endif
  input  logic             arith,
  input  logic             start,
  input  logic [CW-1:0]    shamt,
  output logic [WIDTH-1:0] x_out,
  output logic             s_out,
  output logic             x_zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] x_reg, x_n;
  logic             s_reg, s_n;
  logic             done_reg, done_n;

  logic [WIDTH-1:0] x_shr;
  logic             fill;
  logic [CW-1:0]    amt_sat;

  // Fill bit is re-evaluated every edge so arith/s_in may change mid-burst.
  assign fill    = arith ? x_reg[WIDTH-1] : s_in;
  assign x_shr   = {fill, x_reg[WIDTH-1:1]};
  assign amt_sat = (shamt > CW'(WIDTH)) ? CW'(WIDTH) : shamt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      x_reg    <= '0;
      s_reg    <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      x_reg    <= x_n;
      s_reg    <= s_n;
      done_reg <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    x_n     = x_reg;
    s_n     = s_reg;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (ld) begin
          x_n = x_in;
        end else if (start) begin
          if (shamt == '0) begin
            done_n = 1'b1;
          end else begin
            cnt_n   = amt_sat;
            state_n = SHIFT;
          end
        end else if (shr) begin
          x_n = x_shr;
          s_n = x_reg[0];
`ifdef SHIFT_REGISTER_SHL_EN
        end else if (shl) begin
          x_n = {x_reg[WIDTH-2:0], s_in};
          s_n = x_reg[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        // A load aborts the burst without signalling completion.
        if (ld) begin
          x_n     = x_in;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          x_n   = x_shr;
          s_n   = x_reg[0];
          cnt_n = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign x_out  = x_reg;
  assign s_out  = s_reg;
  assign x_zero = (x_reg == '0);
  assign busy   = (state == SHIFT);
  assign done   = done_reg;

endmodule

// File: tb/tb_shift_register_param.sv
// tb/tb_shift_register_param.sv - directed self-checking bench for shift_register_param
// Covers the SHIFT_REGISTER_SHL_EN left shift when that macro is defined.
module tb_shift_register_param;

  logic       clk = 1'b0;
  logic       rst, ld, s_in, shr, arith, start;
  logic [7:0] x_in;
  logic [3:0] shamt;
  logic [7:0] x_out;
  logic       s_out, x_zero, busy, done;
`ifdef SHIFT_REGISTER_SHL_EN
  logic       shl = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  shift_register_param #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .ld(ld), .s_in(s_in), .shr(shr),
`ifdef SHIFT_REGISTER_SHL_EN
    .shl(shl),
`endif
    .arith(arith), .start(start), .shamt(shamt),
    .x_out(x_out), .s_out(s_out), .x_zero(x_zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a start of amt and watches 14 cycles; start/shr stay asserted for hold edges after the start edge.
  task automatic burst(input logic [3:0] amt, input int hold, output int busy_n, output int done_n,
                       output int done_idx, output int fall_idx);
    busy_n = 0; done_n = 0; done_idx = -1; fall_idx = -1;
    start = 1'b1; shamt = amt;
    for (int i = 0; i < 14; i++) begin
      step();
      if (i >= hold) begin start = 1'b0; shr = 1'b0; end
      if (busy) busy_n++;
      if (done) begin done_n++; if (done_idx < 0) done_idx = i; end
      if (!busy && busy_n > 0 && fall_idx < 0) fall_idx = i;
    end
  endtask

  task automatic load(input logic [7:0] v);
    ld = 1'b1; x_in = v; step(); ld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); rst = 1'b0;
    total++; if (x_out !== 8'h00) begin bad++; $display("FAIL reset_x_out got=%h want=00", x_out); end
    total++; if (s_out !== 1'b0) begin bad++; $display("FAIL reset_s_out got=%b want=0", s_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (x_zero !== 1'b1) begin bad++; $display("FAIL reset_x_zero got=%b want=1", x_zero); end
  endtask

  task automatic test_logical_step();
    load(8'h96);
    shr = 1'b1; s_in = 1'b1; arith = 1'b0; step(); shr = 1'b0;
    total++; if (x_out !== 8'hCB) begin bad++; $display("FAIL shr_x_out got=%h want=cb", x_out); end
    total++; if (s_out !== 1'b0) begin bad++; $display("FAIL shr_s_out got=%b want=0", s_out); end
    total++; if (x_zero !== 1'b0) begin bad++; $display("FAIL shr_x_zero got=%b want=0", x_zero); end
    ld = 1'b1; shr = 1'b1; x_in = 8'hA5; step(); ld = 1'b0; shr = 1'b0;
    total++; if (x_out !== 8'hA5) begin bad++; $display("FAIL ld_over_shr_x_out got=%h want=a5", x_out); end
    total++; if (s_out !== 1'b0) begin bad++; $display("FAIL ld_over_shr_s_out got=%b want=0", s_out); end
  endtask

  task automatic test_arith_burst();
    int bn, dn, di, fi;
    load(8'h96);
    arith = 1'b1; s_in = 1'b0;
    burst(4'd3, 0, bn, dn, di, fi);
    total++; if (bn !== 3) begin bad++; $display("FAIL arith_busy_cycles got=%0d want=3", bn); end
    total++; if (dn !== 1) begin bad++; $display("FAIL arith_done_count got=%0d want=1", dn); end
    total++; if (di !== 3 || fi !== 3) begin bad++; $display("FAIL arith_done_at_fall got=%0d/%0d want=3/3", di, fi); end
    total++; if (x_out !== 8'hF2) begin bad++; $display("FAIL arith_x_out got=%h want=f2", x_out); end
    total++; if (s_out !== 1'b1) begin bad++; $display("FAIL arith_s_out got=%b want=1", s_out); end
  endtask

  task automatic test_zero_saturate();
    int bn, dn, di, fi;
    load(8'h96);
    arith = 1'b0; s_in = 1'b0;
    burst(4'd0, 0, bn, dn, di, fi);
    total++; if (bn !== 0) begin bad++; $display("FAIL zero_busy_cycles got=%0d want=0", bn); end
    total++; if (dn !== 1 || di !== 0) begin bad++; $display("FAIL zero_done got=%0d@%0d want=1@0", dn, di); end
    total++; if (x_out !== 8'h96) begin bad++; $display("FAIL zero_x_out got=%h want=96", x_out); end
    burst(4'd15, 0, bn, dn, di, fi);
    total++; if (bn !== 8) begin bad++; $display("FAIL sat_busy_cycles got=%0d want=8", bn); end
    total++; if (dn !== 1 || di !== 8) begin bad++; $display("FAIL sat_done got=%0d@%0d want=1@8", dn, di); end
    total++; if (x_out !== 8'h00) begin bad++; $display("FAIL sat_x_out got=%h want=00", x_out); end
    total++; if (x_zero !== 1'b1) begin bad++; $display("FAIL sat_x_zero got=%b want=1", x_zero); end
  endtask

  task automatic test_abort();
    int dn;
    dn = 0;
    load(8'h96);
    start = 1'b1; shamt = 4'd5; step(); start = 1'b0;
    if (done) dn++;
    step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b want=1", busy); end
    if (done) dn++;
    ld = 1'b1; x_in = 8'h3C; step(); ld = 1'b0;
    total++; if (x_out !== 8'h3C) begin bad++; $display("FAIL abort_x_out got=%h want=3c", x_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    for (int i = 0; i < 8; i++) begin
      if (done) dn++;
      step();
    end
    total++; if (dn !== 0) begin bad++; $display("FAIL abort_done_count got=%0d want=0", dn); end
    total++; if (x_out !== 8'h3C) begin bad++; $display("FAIL abort_hold got=%h want=3c", x_out); end
  endtask

  task automatic test_ignored();
    int bn, dn, di, fi;
    load(8'h96);
    arith = 1'b0; s_in = 1'b0; shr = 1'b1;
    burst(4'd3, 2, bn, dn, di, fi);
    total++; if (bn !== 3) begin bad++; $display("FAIL ignored_busy_cycles got=%0d want=3", bn); end
    total++; if (dn !== 1) begin bad++; $display("FAIL ignored_done_count got=%0d want=1", dn); end
    total++; if (x_out !== 8'h12) begin bad++; $display("FAIL ignored_x_out got=%h want=12", x_out); end
    total++; if (s_out !== 1'b1) begin bad++; $display("FAIL ignored_s_out got=%b want=1", s_out); end
  endtask

  task automatic test_reset_mid_burst();
    load(8'hF0);
    start = 1'b1; shamt = 4'd8; step(); start = 1'b0;
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    total++; if (busy !== 1'b0 || x_out !== 8'h00) begin bad++; $display("FAIL rst_mid busy/x got=%b/%h want=0/00", busy, x_out); end
    step();
    total++; if (done !== 1'b0 || x_out !== 8'h00) begin bad++; $display("FAIL rst_mid_after done/x got=%b/%h want=0/00", done, x_out); end
  endtask

`ifdef SHIFT_REGISTER_SHL_EN
  task automatic test_shl();
    load(8'h81);
    shl = 1'b1; s_in = 1'b0; step(); shl = 1'b0;
    total++; if (x_out !== 8'h02) begin bad++; $display("FAIL shl_x_out got=%h want=02", x_out); end
    total++; if (s_out !== 1'b1) begin bad++; $display("FAIL shl_s_out got=%b want=1", s_out); end
  endtask
`endif

  initial begin
    rst = 1'b0; ld = 1'b0; s_in = 1'b0; shr = 1'b0; arith = 1'b0;
    start = 1'b0; x_in = 8'h00; shamt = 4'd0;
    test_reset();
    test_logical_step();
    test_arith_burst();
    test_zero_saturate();
    test_abort();
    test_ignored();
    test_reset_mid_burst();
`ifdef SHIFT_REGISTER_SHL_EN
    test_shl();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
